qpi_line_xfer: RTL and testbench

QPI_LINE_XFER -- requirements
Module: qpi_line_xfer

---
 rtl/qpi_line_pkg.sv | 23 ++
 rtl/qpi_line_watchdog.sv | 28 ++
 rtl/qpi_line_xfer.sv | 144 ++++++++++++++
 tb/tb_qpi_line_xfer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qpi_line_pkg.sv
// Shared types and constants for the QPI cache-line transfer engine.
package qpi_line_pkg;

  localparam int QPI_AW             = 25;
  localparam int QPI_DW             = 32;
  localparam int LINE_WORDS_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_XFER,
    ST_DONE
  } xfer_state_t;

  // Clears the word-index and byte-offset bits so the address names the line start.
  function automatic logic [QPI_AW-1:0] line_base(input logic [QPI_AW-1:0] addr,
                                                  input int idx_w);
    logic [QPI_AW-1:0] mask;
    mask = {QPI_AW{1'b1}} << (idx_w + 2);
    return addr & mask;
  endfunction

endpackage

// File: rtl/qpi_line_watchdog.sv
// Counts active cycles since the last kick and flags expiry after TIMEOUT_CYCLES.
module qpi_line_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_kick,
  output logic o_expire
);

  localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Restarts whenever the burst is inactive, progresses, or has just expired.
  always_ff @(posedge clk) begin
    if (rst || !i_active || i_kick || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_active && !i_kick && (r_count == LIMIT);

endmodule

// File: rtl/qpi_line_xfer.sv
// Moves one cache line between the cache and a QPI master, as refill or writeback.
// Optional watchdog abort is enabled by defining QPI_LINE_XFER_TIMEOUT_EN.
module qpi_line_xfer
  import qpi_line_pkg::*;
#(
  parameter int LINE_WORDS     = LINE_WORDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_write,
  input  logic [QPI_AW-1:0]             i_req_addr,
  output logic [$clog2(LINE_WORDS)-1:0] o_wb_idx,
  input  logic [QPI_DW-1:0]             i_wb_data,
  output logic                          o_fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] o_fill_idx,
  output logic [QPI_DW-1:0]             o_fill_data,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_qpi_do_read,
  output logic                          o_qpi_do_write,
  output logic [QPI_AW-1:0]             o_qpi_addr,
  output logic [QPI_DW-1:0]             o_qpi_wdata,
  input  logic [QPI_DW-1:0]             i_qpi_rdata,
  input  logic                          i_qpi_next_word,
  input  logic                          i_qpi_is_idle
);

  localparam int               IDX_W    = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  if ((LINE_WORDS < 2) || (LINE_WORDS > 32) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)
      || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("qpi_line_xfer: illegal LINE_WORDS or TIMEOUT_CYCLES");
  end

  xfer_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_write, w_write_nxt;
  logic [QPI_AW-1:0] r_addr, w_addr_nxt;
  logic              r_do_read, w_do_read_nxt;
  logic              r_do_write, w_do_write_nxt;
  logic              w_in_xfer;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_timeout;

  assign w_in_xfer   = (r_state == ST_XFER);
  assign w_beat      = w_in_xfer && i_qpi_next_word;
  assign w_last_beat = w_beat && (r_cnt == LAST_IDX);

`ifdef QPI_LINE_XFER_TIMEOUT_EN
  qpi_line_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_in_xfer),
    .i_kick   (i_qpi_next_word),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_do_read  <= 1'b0;
      r_do_write <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_write    <= w_write_nxt;
      r_addr     <= w_addr_nxt;
      r_do_read  <= w_do_read_nxt;
      r_do_write <= w_do_write_nxt;
    end
  end

  // The do_* strobes are registered, so they change one cycle after the decision here.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_write_nxt    = r_write;
    w_addr_nxt     = r_addr;
    w_do_read_nxt  = r_do_read;
    w_do_write_nxt = r_do_write;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = ST_WAIT_IDLE;
          w_write_nxt = i_req_write;
          w_addr_nxt  = line_base(i_req_addr, IDX_W);
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_IDLE: begin
        if (i_qpi_is_idle) begin
          w_state_nxt    = ST_XFER;
          w_do_read_nxt  = !r_write;
          w_do_write_nxt = r_write;
        end
      end
      ST_XFER: begin
        if (w_timeout) begin
          w_state_nxt    = ST_IDLE;
          w_do_read_nxt  = 1'b0;
          w_do_write_nxt = 1'b0;
        end else if (w_last_beat) begin
          w_state_nxt    = ST_DONE;
          w_do_read_nxt  = 1'b0;
          w_do_write_nxt = 1'b0;
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready    = (r_state == ST_IDLE);
  assign o_done         = (r_state == ST_DONE);
  assign o_err          = w_timeout;
  assign o_wb_idx       = r_cnt;
  assign o_qpi_wdata    = i_wb_data;
  assign o_qpi_addr     = r_addr;
  assign o_qpi_do_read  = r_do_read;
  assign o_qpi_do_write = r_do_write;
  assign o_fill_valid   = w_beat && !r_write;
  assign o_fill_idx     = r_cnt;
  assign o_fill_data    = i_qpi_rdata;

endmodule

// File: tb/tb_qpi_line_xfer.sv
// Directed self-checking bench for qpi_line_xfer (LINE_WORDS=8, TIMEOUT_CYCLES=16).
`timescale 1ns/1ps
module tb_qpi_line_xfer;

  localparam int LW = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid, reqReady, reqWrite;
  logic [24:0] reqAddr;
  logic [2:0]  wbIdx, fillIdx;
  logic [31:0] wbData, fillData, qpiWdata, qpiRdata;
  logic        fillValid, done, err;
  logic        qpiDoRead, qpiDoWrite, qpiNextWord, qpiIsIdle;
  logic [24:0] qpiAddr;

  int checkCount = 0;
  int failCount  = 0;
  int cycle      = 0;

  qpi_line_xfer #(
    .LINE_WORDS     (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (reqValid),
    .o_req_ready     (reqReady),
    .i_req_write     (reqWrite),
    .i_req_addr      (reqAddr),
    .o_wb_idx        (wbIdx),
    .i_wb_data       (wbData),
    .o_fill_valid    (fillValid),
    .o_fill_idx      (fillIdx),
    .o_fill_data     (fillData),
    .o_done          (done),
    .o_err           (err),
    .o_qpi_do_read   (qpiDoRead),
    .o_qpi_do_write  (qpiDoWrite),
    .o_qpi_addr      (qpiAddr),
    .o_qpi_wdata     (qpiWdata),
    .i_qpi_rdata     (qpiRdata),
    .i_qpi_next_word (qpiNextWord),
    .i_qpi_is_idle   (qpiIsIdle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // The cache side returns a recognisable word for each index.
  assign wbData = 32'hA0 + 32'(wbIdx);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic nextWord,
                               input logic isIdle, input logic [31:0] rdata);
    reqValid    = valid;
    qpiNextWord = nextWord;
    qpiIsIdle   = isIdle;
    qpiRdata    = rdata;
    #2;
  endtask

  // One full transaction; gap idle cycles precede each next_word pulse.
  task automatic doTransfer(input logic write, input logic [24:0] addr, input int gap);
    int          acceptCycle;
    logic [24:0] base;
    logic [31:0] rd;
    base = addr & ~25'h1F;
    nextCycle();
    reqWrite = write;
    reqAddr  = addr;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    checkOutput("req_ready_idle", reqReady, 1);
    acceptCycle = cycle;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("req_ready_busy", reqReady, 0);
    checkOutput("do_low_in_wait", {qpiDoRead, qpiDoWrite}, 0);
    for (int i = 0; i < LW; i++) begin
      for (int g = 0; g < gap; g++) begin
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("do_gap", {qpiDoRead, qpiDoWrite}, {!write, write});
        checkOutput("wdata_held", qpiWdata, 32'hA0 + 32'(i));
        checkOutput("fill_valid_gap", fillValid, 0);
      end
      nextCycle();
      rd = 32'hC0DE0000 + 32'(i);
      applyStimulus(1'b0, 1'b1, 1'b1, rd);
      checkOutput("do_beat", {qpiDoRead, qpiDoWrite}, {!write, write});
      checkOutput("qpi_addr", qpiAddr, base);
      if (write) begin
        checkOutput("wb_idx", wbIdx, i);
        checkOutput("wdata_beat", qpiWdata, 32'hA0 + 32'(i));
        checkOutput("fill_valid_wr", fillValid, 0);
      end else begin
        checkOutput("fill_valid", fillValid, 1);
        checkOutput("fill_idx", fillIdx, i);
        checkOutput("fill_data", fillData, rd);
      end
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("done_pulse", done, 1);
    checkOutput("do_low_after_last", {qpiDoRead, qpiDoWrite}, 0);
    checkOutput("latency", cycle - acceptCycle, 2 + LW * (gap + 1));
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("done_single", done, 0);
    checkOutput("req_ready_after", reqReady, 1);
  endtask

  initial begin
    rst = 1'b1;
    reqWrite = 1'b0;
    reqAddr  = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_req_ready", reqReady, 1);
    checkOutput("rst_do", {qpiDoRead, qpiDoWrite}, 0);
    checkOutput("rst_addr", qpiAddr, 0);
    checkOutput("rst_flags", {fillValid, done, err}, 0);
    rst = 1'b0;

    // Refill with back-to-back beats, then writeback with a beat every third cycle.
    doTransfer(1'b0, 25'h000123, 0);
    doTransfer(1'b1, 25'h1ABCDEF, 2);

    // Downstream busy: is_idle low in the accept cycle and four wait cycles.
    nextCycle();
    reqWrite = 1'b0;
    reqAddr  = 25'h000200;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      applyStimulus(1'b0, (k == 2), (k == 5), 32'hDEAD);
      checkOutput("busy_do_low", {qpiDoRead, qpiDoWrite}, 0);
      checkOutput("busy_fill_valid", fillValid, 0);
    end
    for (int i = 0; i < LW; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h11 + 32'(i));
      checkOutput("busy_do_read", qpiDoRead, 1);
      checkOutput("busy_fill_idx", fillIdx, i);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("busy_done", done, 1);

    // Back-to-back: req_valid and next_word held high across two refills.
    for (int k = 0; k <= 21; k++) begin
      nextCycle();
      reqAddr = (k < 11) ? 25'h000040 : 25'h0000A0;
      applyStimulus((k <= 11), 1'b1, 1'b1, 32'h100 + 32'(k));
      checkOutput("b2b_ready", reqReady, (k == 0 || k == 11));
      checkOutput("b2b_done", done, (k == 10 || k == 21));
      checkOutput("b2b_fill_valid", fillValid, ((k >= 2 && k <= 9) || (k >= 13 && k <= 20)));
      if (k >= 2 && k <= 9) checkOutput("b2b_fill_idx1", fillIdx, k - 2);
      if (k >= 13 && k <= 20) checkOutput("b2b_fill_idx2", fillIdx, k - 13);
      if (k >= 1) checkOutput("b2b_addr", qpiAddr, (k <= 11) ? 25'h000040 : 25'h0000A0);
    end

    // Reset in the cycle after the third beat abandons the burst.
    nextCycle();
    reqWrite = 1'b0;
    reqAddr  = 25'h000300;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h55);
      checkOutput("pre_rst_fill_idx", fillIdx, i);
    end
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("pre_rst_do_read", qpiDoRead, 1);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77);
    checkOutput("post_rst_do", {qpiDoRead, qpiDoWrite}, 0);
    checkOutput("post_rst_flags", {fillValid, done, err}, 0);
    checkOutput("post_rst_ready", reqReady, 1);
    checkOutput("post_rst_wb_idx", wbIdx, 0);
    doTransfer(1'b0, 25'h000300, 0);

    // Stalled burst: no next_word after entering XFER.
    nextCycle();
    reqWrite = 1'b0;
    reqAddr  = 25'h000400;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
`ifdef QPI_LINE_XFER_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("wd_err", err, (k == TO));
      checkOutput("wd_do_read", qpiDoRead, 1);
      checkOutput("wd_done", done, 0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("wd_err_single", err, 0);
    checkOutput("wd_do_cleared", {qpiDoRead, qpiDoWrite}, 0);
    checkOutput("wd_ready", reqReady, 1);
    checkOutput("wd_no_done", done, 0);
`else
    for (int k = 1; k <= 3 * TO; k++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("stall_err", err, 0);
    end
    checkOutput("stall_do_read", qpiDoRead, 1);
    for (int i = 0; i < LW; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
      checkOutput("stall_fill_idx", fillIdx, i);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("stall_done", done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
